// File: rtl/sid_pkg.sv
// Shared SID types: register widths, core bus bundle, bus-master request and state.
// Types only, so there is no latency.
// Carries no flow control of its own.
package sid;

    typedef logic [4:0] reg5_t;
    typedef logic [7:0] reg8_t;

    typedef struct packed {
        reg5_t addr;
        reg8_t data;
        logic  phi2;
        logic  r_w_n;
        logic  res;
    } bus_i_t;

    typedef struct packed {
        logic  write;
        reg5_t addr;
        reg8_t data;
    } bus_req_t;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2
    } bus_master_state_e;

endpackage

// File: rtl/sid_phi2_gen.sv
// Free-running phi2 generator with strobes that flag the upcoming phi1 start and phi2 rise.
// phi2 is registered; the strobes are decoded from cnt and are valid one cycle ahead of their edge.
// Never stalls: it runs from reset release onward, with no flow control.
module sid_phi2_gen #(
    parameter int HALF_PERIOD = 12
) (
    input  logic clk,
    input  logic rst_n,
    output logic phi2,
    output logic boundary,
    output logic phi2_rise
);

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    // Strobes are true in the cycle whose closing edge wraps cnt or raises phi2.
    assign boundary  = (cnt == CNT_LAST);
    assign phi2_rise = (cnt == CNT_RISE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            phi2 <= 1'b0;
        end else begin
            cnt <= boundary ? '0 : cnt + CW'(1);
            if (phi2_rise) begin
                phi2 <= 1'b1;
            end else if (boundary) begin
                phi2 <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sid_bus_master.sv
// Drives the SID core bus from a one-deep valid/ready request port, with phi2 and reset sequencing.
// A request launches at the next phi1 start; read data returns 2*HALF_PERIOD cycles after launch.
// req_ready drops while a request is buffered or the reset sequence is running.
module sid_bus_master
    import sid::*;
#(
    parameter int HALF_PERIOD = 12,
    parameter int RES_PHI2    = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sw_reset,
    input  logic   req_valid,
    output logic   req_ready,
    input  logic   req_write,
    input  reg5_t  req_addr,
    input  reg8_t  req_data,
    output logic   rsp_valid,
    output reg8_t  rsp_data,
    input  reg8_t  data_i,
    output bus_i_t bus_o,
    output logic   cs_n
);

    localparam int RCW = (RES_PHI2 > 1) ? $clog2(RES_PHI2) : 1;
    localparam logic [RCW-1:0] RES_LAST = RCW'(RES_PHI2 - 1);

    logic phi2, boundary, phi2_rise;

    bus_master_state_e state_q, state_d;
    logic [RCW-1:0]    res_cnt_q, res_cnt_d;
    logic              pending_q, pending_d;
    bus_req_t          hold_q, hold_d;
    bus_req_t          cur_q, cur_d;
    logic              in_acc;
    logic              cs_n_d, r_w_n_q, r_w_n_d, res_q, res_d, ready_d, rsp_valid_d;
    reg5_t             addr_q, addr_d;
    reg8_t             data_q, data_d, rsp_data_d;

    sid_phi2_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phi2_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .phi2      (phi2),
        .boundary  (boundary),
        .phi2_rise (phi2_rise)
    );

    always_comb begin
        state_d     = state_q;
        res_cnt_d   = res_cnt_q;
        pending_d   = pending_q;
        hold_d      = hold_q;
        cur_d       = cur_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;

        if (req_valid && req_ready) begin
            pending_d = 1'b1;
            hold_d    = '{write: req_write, addr: req_addr, data: req_data};
        end

        // All state changes happen on the edge that starts phi1.
        if (boundary) begin
            case (state_q)
                RESET: begin
                    if (res_cnt_q == RES_LAST) begin
                        state_d = IDLE;
                    end else begin
                        res_cnt_d = res_cnt_q + RCW'(1);
                    end
                end
                IDLE: begin
                    if (pending_q) begin
                        state_d   = ACCESS;
                        cur_d     = hold_q;
                        pending_d = 1'b0;
                    end
                end
                ACCESS: begin
                    if (!cur_q.write) begin
                        rsp_data_d  = data_i;
                        rsp_valid_d = 1'b1;
                    end
                    if (pending_q) begin
                        cur_d     = hold_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = RESET;
            endcase
        end

        // Software reset overrides the boundary work and any same-cycle acceptance.
        if (sw_reset) begin
            state_d     = RESET;
            res_cnt_d   = '0;
            pending_d   = 1'b0;
            rsp_valid_d = 1'b0;
            rsp_data_d  = rsp_data;
        end

        in_acc  = (state_d == ACCESS);
        cs_n_d  = !in_acc;
        r_w_n_d = in_acc ? !cur_d.write : 1'b1;
        addr_d  = in_acc ? cur_d.addr : '0;
        res_d   = (state_d == RESET);
        ready_d = !pending_d && (state_d != RESET);

        // Write data is only presented while phi2 is high.
        if (!in_acc || boundary) begin
            data_d = '0;
        end else if (phi2_rise && cur_d.write) begin
            data_d = cur_d.data;
        end else begin
            data_d = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET;
            res_cnt_q <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            cur_q     <= '0;
            cs_n      <= 1'b1;
            r_w_n_q   <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            res_q     <= 1'b1;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            res_cnt_q <= res_cnt_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            cur_q     <= cur_d;
            cs_n      <= cs_n_d;
            r_w_n_q   <= r_w_n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            res_q     <= res_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
        end
    end

    assign bus_o = '{addr: addr_q, data: data_q, phi2: phi2, r_w_n: r_w_n_q, res: res_q};

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master with HALF_PERIOD=4, RES_PHI2=3.
module tb_sid_bus_master;
    import sid::*;

    localparam int HP = 4;
    localparam int RP = 3;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   sw_reset = 1'b0;
    logic   req_valid = 1'b0;
    logic   req_write = 1'b0;
    reg5_t  req_addr = '0;
    reg8_t  req_data = '0;
    reg8_t  data_i = '0;
    logic   req_ready, rsp_valid, cs_n;
    reg8_t  rsp_data;
    bus_i_t bus_o;

    int n_vec = 0;
    int n_err = 0;
    int tb_cnt;

    sid_bus_master #(
        .HALF_PERIOD(HP),
        .RES_PHI2   (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_reset  (sw_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .data_i    (data_i),
        .bus_o     (bus_o),
        .cs_n      (cs_n)
    );

    always #5 clk = ~clk;

    // Reference phase counter: 0 right after a phi1-start edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == 2 * HP - 1) ? 0 : tb_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_boundary();
        int i;
        for (i = 0; i < 4 * HP; i++) begin
            if (tb_cnt == 0) break;
            step();
        end
        n_vec++;
        if (tb_cnt != 0) begin
            n_err++;
            $display("FAIL wait_boundary: phase %0d, required 0", tb_cnt);
        end
    endtask

    task automatic run_reset_seq(input string tag);
        for (int k = 1; k <= 26; k++) begin
            step();
            n_vec++;
            if (bus_o.phi2 !== ((k % 8) >= 4)) begin
                n_err++;
                $display("FAIL %s phi2 k=%0d: got %b want %b", tag, k, bus_o.phi2, (k % 8) >= 4);
            end
            n_vec++;
            if (bus_o.res !== (k < 24)) begin
                n_err++;
                $display("FAIL %s res k=%0d: got %b want %b", tag, k, bus_o.res, k < 24);
            end
            n_vec++;
            if (req_ready !== (k >= 24)) begin
                n_err++;
                $display("FAIL %s req_ready k=%0d: got %b want %b", tag, k, req_ready, k >= 24);
            end
            n_vec++;
            if (cs_n !== 1'b1) begin
                n_err++;
                $display("FAIL %s cs_n k=%0d: got %b want 1", tag, k, cs_n);
            end
        end
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++;
        if (bus_o !== 15'b00000_00000000_0_1_1) begin
            n_err++;
            $display("FAIL reset bus_o: got %h want %h", bus_o, 15'b00000_00000000_0_1_1);
        end
        n_vec++;
        if ({cs_n, req_ready, rsp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL reset ctrl: got %b want 100", {cs_n, req_ready, rsp_valid});
        end
        n_vec++;
        if (rsp_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset rsp_data: got %h want 00", rsp_data);
        end
        rst_n = 1'b1;
        run_reset_seq("reset_seq");
    endtask

    task automatic test_write();
        int r;
        wait_boundary();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write ready: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h18; req_data = 8'h0F;
        step();
        req_valid = 1'b0;
        r = 1;
        while (cs_n === 1'b1 && r < 20) begin
            step();
            r++;
        end
        n_vec++;
        if (r != 8) begin
            n_err++;
            $display("FAIL write launch latency: got %0d want 8", r);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({cs_n, bus_o.addr, bus_o.r_w_n, bus_o.phi2, rsp_valid} !== {1'b0, 5'h18, 1'b0, i >= 4, 1'b0}) begin
                n_err++;
                $display("FAIL write ctrl i=%0d: got cs=%b a=%h rw=%b p=%b rv=%b want cs=0 a=18 rw=0 p=%b rv=0",
                         i, cs_n, bus_o.addr, bus_o.r_w_n, bus_o.phi2, rsp_valid, i >= 4);
            end
            n_vec++;
            if (bus_o.data !== ((i >= 4) ? 8'h0F : 8'h00)) begin
                n_err++;
                $display("FAIL write data i=%0d: got %h want %h", i, bus_o.data, (i >= 4) ? 8'h0F : 8'h00);
            end
            step();
        end
        n_vec++;
        if ({cs_n, bus_o.r_w_n, bus_o.addr, bus_o.data, rsp_valid} !== {1'b1, 1'b1, 5'h00, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL write end: got cs=%b rw=%b a=%h d=%h rv=%b want 1 1 00 00 0",
                     cs_n, bus_o.r_w_n, bus_o.addr, bus_o.data, rsp_valid);
        end
    endtask

    task automatic test_read();
        int r;
        wait_boundary();
        data_i = 8'hA5;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h1B; req_data = 8'h00;
        step();
        req_valid = 1'b0;
        r = 1;
        while (cs_n === 1'b1 && r < 20) begin
            step();
            r++;
        end
        n_vec++;
        if (r != 8) begin
            n_err++;
            $display("FAIL read launch latency: got %0d want 8", r);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({cs_n, bus_o.addr, bus_o.r_w_n, bus_o.data, rsp_valid, rsp_data} !==
                {1'b0, 5'h1B, 1'b1, 8'h00, 1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL read access i=%0d: got cs=%b a=%h rw=%b d=%h rv=%b rd=%h want 0 1b 1 00 0 00",
                         i, cs_n, bus_o.addr, bus_o.r_w_n, bus_o.data, rsp_valid, rsp_data);
            end
            step();
        end
        n_vec++;
        if ({cs_n, rsp_valid, rsp_data} !== {1'b1, 1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL read rsp: got cs=%b rv=%b rd=%h want 1 1 a5", cs_n, rsp_valid, rsp_data);
        end
        data_i = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if ({rsp_valid, rsp_data} !== {1'b0, 8'hA5}) begin
                n_err++;
                $display("FAIL read hold i=%0d: got rv=%b rd=%h want 0 a5", i, rsp_valid, rsp_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        reg5_t addrs [2];
        reg8_t datas [2];
        int    acc_r [2];
        int    idx;
        logic  rdy_prev;
        logic  e_cs;
        reg5_t e_addr;
        reg8_t e_data;
        addrs[0] = 5'h00; addrs[1] = 5'h01;
        datas[0] = 8'h11; datas[1] = 8'h22;
        acc_r[0] = -1; acc_r[1] = -1;
        idx = 0;
        wait_boundary();
        req_valid = 1'b1; req_write = 1'b1; req_addr = addrs[0]; req_data = datas[0];
        rdy_prev = req_ready;
        for (int r = 1; r <= 26; r++) begin
            step();
            if (req_valid && rdy_prev) begin
                acc_r[idx] = r;
                idx++;
                if (idx < 2) begin
                    req_addr = addrs[idx];
                    req_data = datas[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            rdy_prev = req_ready;
            e_cs   = !(r >= 8 && r < 24);
            e_addr = (r >= 16 && r < 24) ? 5'h01 : 5'h00;
            e_data = (r >= 12 && r < 16) ? 8'h11 : (r >= 20 && r < 24) ? 8'h22 : 8'h00;
            n_vec++;
            if ({cs_n, bus_o.r_w_n, bus_o.addr, bus_o.data} !== {e_cs, e_cs, e_addr, e_data}) begin
                n_err++;
                $display("FAIL b2b r=%0d: got cs=%b rw=%b a=%h d=%h want cs=%b rw=%b a=%h d=%h",
                         r, cs_n, bus_o.r_w_n, bus_o.addr, bus_o.data, e_cs, e_cs, e_addr, e_data);
            end
        end
        req_valid = 1'b0;
        n_vec++;
        if (acc_r[0] != 1 || acc_r[1] != 9) begin
            n_err++;
            $display("FAIL b2b accept cycles: got %0d,%0d want 1,9", acc_r[0], acc_r[1]);
        end
    endtask

    task automatic test_sw_reset();
        logic e_cs, e_res, e_rdy;
        wait_boundary();
        data_i = 8'h77;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h05; req_data = 8'h00;
        for (int r = 1; r <= 58; r++) begin
            step();
            e_cs  = !(r >= 8 && r < 14);
            e_res = (r >= 14 && r < 32) || (r >= 33 && r < 56);
            e_rdy = (r >= 8 && r < 14) || (r == 32) || (r >= 56);
            n_vec++;
            if ({cs_n, bus_o.res, req_ready} !== {e_cs, e_res, e_rdy}) begin
                n_err++;
                $display("FAIL swrst ctrl r=%0d: got cs=%b res=%b rdy=%b want cs=%b res=%b rdy=%b",
                         r, cs_n, bus_o.res, req_ready, e_cs, e_res, e_rdy);
            end
            n_vec++;
            if ({rsp_valid, rsp_data, bus_o.phi2} !== {1'b0, 8'hA5, tb_cnt >= HP}) begin
                n_err++;
                $display("FAIL swrst rsp/phi2 r=%0d: got rv=%b rd=%h p=%b want 0 a5 %b",
                         r, rsp_valid, rsp_data, bus_o.phi2, tb_cnt >= HP);
            end
            if (r == 14) begin
                n_vec++;
                if ({bus_o.r_w_n, bus_o.addr, bus_o.data} !== {1'b1, 5'h00, 8'h00}) begin
                    n_err++;
                    $display("FAIL swrst bus idle: got rw=%b a=%h d=%h want 1 00 00",
                             bus_o.r_w_n, bus_o.addr, bus_o.data);
                end
            end
            req_valid = 1'b0;
            sw_reset  = 1'b0;
            if (r == 13) sw_reset = 1'b1;
            if (r == 32) begin
                sw_reset  = 1'b1;
                req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h03; req_data = 8'h44;
            end
        end
    endtask

    task automatic test_async_reset();
        wait_boundary();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h0A; req_data = 8'h5A;
        step();
        req_valid = 1'b0;
        for (int r = 2; r <= 12; r++) step();
        n_vec++;
        if ({cs_n, bus_o.data} !== {1'b0, 8'h5A}) begin
            n_err++;
            $display("FAIL arst pre: got cs=%b d=%h want 0 5a", cs_n, bus_o.data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus_o !== 15'b00000_00000000_0_1_1) begin
            n_err++;
            $display("FAIL arst bus_o: got %h want %h", bus_o, 15'b00000_00000000_0_1_1);
        end
        n_vec++;
        if ({cs_n, req_ready, rsp_valid, rsp_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL arst ctrl: got cs=%b rdy=%b rv=%b rd=%h want 1 0 0 00",
                     cs_n, req_ready, rsp_valid, rsp_data);
        end
        step();
        step();
        rst_n = 1'b1;
        run_reset_seq("arst_seq");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_sw_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sid_bus_master.md
# sid_bus_master

Bus initiator that drives the SID core's bus input (`sid::bus_i_t`) from a simple valid/ready request port. It generates a continuous phi2 clock, a power-on/software reset sequence, and 6510-style read/write cycles with chip select. It sits between the host command path (USB/debug/test harness) and the SID core, on the core's bus input side.

## Interface
Parameters:
- `HALF_PERIOD`, default 12: clk cycles per phi2 half-period. Minimum 2. Default gives 1 MHz phi2 at 24 MHz.
- `RES_PHI2`, default 16: number of phi2 periods `res` is held after reset. Minimum 1.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `sw_reset`  in  1  one-cycle pulse; restarts the reset sequence
- `req_valid`  in  1  request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  5  register address (`sid::reg5_t`)
- `req_data`  in  8  write data
- `rsp_valid`  out  1  one-cycle read-data strobe
- `rsp_data`  out  8  read data; held until the next read
- `data_i`  in  8  read data from the SID core
- `bus_o`  out  `sid::bus_i_t`  addr, data, phi2, r_w_n, res (res = 1 means reset asserted)
- `cs_n`  out  1  chip select, active low

## Operation
- Phase counter `cnt` runs 0..2·HALF_PERIOD−1 and wraps. `phi2` = (`cnt` ≥ HALF_PERIOD). It runs in all states, including reset.
- A "boundary" is the clk edge at which `cnt` wraps to 0 (start of phi1).
- States:
  - RESET → IDLE after RES_PHI2 boundaries. `res` drops at that boundary.
  - IDLE → ACCESS at a boundary when `pending` is set.
  - ACCESS → ACCESS at the next boundary if a new request is pending; otherwise → IDLE.
- Request buffer is one entry. `req_ready = !pending && state != RESET`. An accepted request sets `pending` and is launched at the next boundary. `pending` clears at the launch edge.
- During ACCESS:
  - `addr` and `r_w_n` are driven for the whole period and `cs_n` = 0.
  - For a write, `bus_o.data` = `req_data` only while `phi2` = 1; otherwise `data` = 0.
  - For a read, `data_i` is sampled at the closing boundary into `rsp_data`, and `rsp_valid` = 1 for the following cycle.
- Outside ACCESS: `cs_n` = 1, `r_w_n` = 1, `addr` = 0, `data` = 0.
- `sw_reset` at any cycle:
  - drops `pending` and aborts any access;
  - next edge: `cs_n` = 1, `res` = 1, state = RESET, RESET period count restarts;
  - `cnt` is not reset;
  - no `rsp_valid` for the aborted read.
- `sw_reset` and request acceptance in the same cycle: `sw_reset` wins and the request is dropped.

## Timing
- Reset values while `rst_n` = 0:
  - `cnt` = 0, `phi2` = 0, state RESET, `res` = 1;
  - `cs_n` = 1, `r_w_n` = 1, `addr` = 0, `data` = 0;
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0.
- All outputs are registered.
- Accept-to-launch latency: 1 to 2·HALF_PERIOD cycles. A request accepted on a boundary edge launches at the following boundary.
- Read latency: launch boundary + 2·HALF_PERIOD cycles to the `rsp_data` update; `rsp_valid` is high in the cycle after that edge.
- Throughput: one access per phi2 period. Back-to-back accesses keep `cs_n` low continuously, and `addr` changes only at boundaries.

## Structure
- Add to package `sid`:
  - `bus_req_t` struct {write, `reg5_t` addr, `reg8_t` data};
  - `bus_master_state_e` enum {RESET, IDLE, ACCESS}.
- Sub-module `sid_phi2_gen`: holds `cnt`, `phi2`, and the `boundary` and `phi2_rise` strobes. Parameter HALF_PERIOD; `clk`/`rst_n` only.

## Test plan
Use HALF_PERIOD = 4, RES_PHI2 = 3.
1. Reset release → `phi2` toggles every 4 clks. `res` = 1 for 24 clks. `req_ready` rises the cycle after the third boundary.
2. Write addr 0x18, data 0x0F → at the next boundary `cs_n` = 0 for exactly 8 clks, `addr` = 0x18, `r_w_n` = 0. `data` = 0x0F only during the 4 phi2-high clks. No `rsp_valid`.
3. Read addr 0x1B with `data_i` = 0xA5 → `r_w_n` = 1 and `cs_n` low for 8 clks. `rsp_valid` pulses once with `rsp_data` = 0xA5. `rsp_data` holds afterwards.
4. Two writes (0x00/0x11, 0x01/0x22) offered continuously → the second is accepted the cycle after the first launch. `cs_n` stays low for 16 clks, and `addr` changes 0x00→0x01 at the boundary.
5. `sw_reset` during the phi2-high half of a read → next edge: `cs_n` = 1, `res` = 1. No `rsp_valid`. `req_ready` = 0 for 3 periods. `phi2` is uninterrupted.
6. `rst_n` asserted mid-write, with no clk edge → all outputs take their reset values immediately. After release, test 1's sequence repeats.
